layer_ctrl: RTL and testbench

Per-layer sequencer for the 3x3 window wrapper and its compute-in-memory macro. It runs the layer in three phases. First it loads the macro parameters, with `mode` held low. It then streams FM_REPEAT × FM_WIDTH² pixels into the wrapper with `mode` high, forwarding frame syncs and policing pixel spacing. Finally it reports frame and layer completion. It sits between the upstream pixel/parameter source and the wrapper's `mode_in`, `verticle_sync` and `data_in_valid` inputs.

---
 rtl/layer_pkg.sv | 24 ++
 rtl/layer_ctrl_pix_gap_mon.sv | 27 ++
 rtl/layer_ctrl.sv | 145 ++++++++++++++
 tb/tb_layer_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared types and sizing for the layer sequencer.
// State encoding, counter widths and the expected window count per frame.
package layer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_VS,
      ST_CALC,
      ST_DRAIN,
      ST_DONE
   } layer_state_t;

   localparam int PIX_CNT_W = 13;
   localparam int WIN_CNT_W = 10;

   // Stride-2 3x3 window: one window per 2x2 pixel block.
   function automatic int win_per_frame(input int fm_width);
      return (fm_width / 2) * (fm_width / 2);
   endfunction

   localparam int WIN_PER_FRAME = win_per_frame(56);

endpackage

// File: rtl/layer_ctrl_pix_gap_mon.sv
// Pixel spacing monitor: sticky flag when two pixels land on consecutive cycles.
// One cycle from offending pixel to flag; never stalls the pixel stream.
module pix_gap_mon (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   input  logic pix,
   output logic err_overrun
);

   logic prev_pix;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         prev_pix    <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         prev_pix <= en & pix;
         if (clr)
            err_overrun <= 1'b0;
         else if (en & pix & prev_pix)
            err_overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/layer_ctrl.sv
// Layer sequencer: parameter load, framed pixel streaming, completion pulses; vs/pixel paths are 0-cycle.
// Parameter port is valid/ready; pixels cannot be stalled. Window-count check under LAYER_CTRL_WINCHK_EN.
module layer_ctrl
   import layer_pkg::*;
#(
   parameter int FM_WIDTH    = 56,
   parameter int PARAM_WORDS = 576,
   parameter int FRAME_W     = 8,
   parameter int DRAIN_CYC   = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [FRAME_W-1:0]   frames_req,
   input  logic                 param_valid,
   output logic                 param_ready,
   output logic [9:0]           param_addr,
   output logic                 param_we,
   input  logic                 vs_in,
   input  logic                 pix_valid_in,
   output logic                 mode_out,
   output logic                 vs_out,
   output logic                 pix_valid_out,
   input  logic                 win_valid,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 layer_done,
   output logic                 err_overrun,
   output logic                 err_win,
   output logic [WIN_CNT_W-1:0] win_count
);

   localparam int PIX_PER_FRAME = FM_WIDTH * FM_WIDTH;
   localparam int DRN_W         = $clog2(DRAIN_CYC + 1);

   layer_state_t         state, state_nxt;
   logic [PIX_CNT_W-1:0] pix_cnt;
   logic [FRAME_W-1:0]   frame_cnt;
   logic [DRN_W-1:0]     drain_cnt;
   logic [WIN_CNT_W-1:0] win_nxt;
   logic streaming, counting, abort, last_pix, drain_end, frame_end, take_start;

   assign streaming     = (state == ST_WAIT_VS) || (state == ST_CALC) || (state == ST_DRAIN);
   assign counting      = (state == ST_CALC) || (state == ST_DRAIN);
   assign vs_out        = vs_in & streaming;
   assign pix_valid_out = pix_valid_in & (state == ST_CALC);
   assign param_we      = param_valid & param_ready;
   assign take_start    = start && (state == ST_IDLE);
   assign abort         = vs_in & counting;
   assign last_pix      = pix_valid_out && (pix_cnt == PIX_CNT_W'(PIX_PER_FRAME - 1));
   assign drain_end     = (state == ST_DRAIN) && (drain_cnt == DRN_W'(DRAIN_CYC - 1));
   assign frame_end     = drain_end && !abort;
   assign win_nxt       = (counting && win_valid && (win_count != '1)) ? win_count + 1'b1 : win_count;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (start) state_nxt = ST_LOAD;
         ST_LOAD:    if (param_we && (param_addr == 10'(PARAM_WORDS - 1))) state_nxt = ST_WAIT_VS;
         ST_WAIT_VS: if (vs_in) state_nxt = ST_CALC;
         ST_CALC:    if (!abort && last_pix) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (abort)
               state_nxt = ST_CALC;
            else if (drain_end)
               state_nxt = (frame_cnt <= FRAME_W'(1)) ? ST_DONE : ST_WAIT_VS;
         end
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         mode_out    <= 1'b0;
         busy        <= 1'b0;
         param_ready <= 1'b0;
         param_addr  <= '0;
         pix_cnt     <= '0;
         win_count   <= '0;
         drain_cnt   <= '0;
         frame_cnt   <= '0;
         frame_done  <= 1'b0;
         layer_done  <= 1'b0;
      end else begin
         state       <= state_nxt;
         mode_out    <= (state_nxt == ST_WAIT_VS) || (state_nxt == ST_CALC) || (state_nxt == ST_DRAIN);
         busy        <= (state_nxt != ST_IDLE);
         param_ready <= (state_nxt == ST_LOAD);
         frame_done  <= 1'b0;
         layer_done  <= (state == ST_DONE);

         if (take_start) begin
            param_addr <= '0;
            frame_cnt  <= (frames_req == '0) ? FRAME_W'(1) : frames_req;
         end else if (param_we) begin
            param_addr <= param_addr + 1'b1;
         end

         // A sync inside a frame restarts it; WAIT_VS holds the counters clear.
         if (abort || (state == ST_WAIT_VS)) begin
            pix_cnt   <= '0;
            win_count <= '0;
            drain_cnt <= '0;
         end else if (state == ST_CALC) begin
            if (pix_valid_out) pix_cnt <= pix_cnt + 1'b1;
            win_count <= win_nxt;
            drain_cnt <= '0;
         end else if (state == ST_DRAIN) begin
            win_count <= win_nxt;
            drain_cnt <= drain_cnt + 1'b1;
            if (frame_end) begin
               frame_done <= 1'b1;
               frame_cnt  <= frame_cnt - 1'b1;
            end
         end
      end
   end

`ifdef LAYER_CTRL_WINCHK_EN
   localparam logic [WIN_CNT_W-1:0] WIN_EXP = WIN_CNT_W'(win_per_frame(FM_WIDTH));

   always_ff @(posedge clk) begin
      if (!rstn)
         err_win <= 1'b0;
      else if (take_start)
         err_win <= 1'b0;
      else if (frame_end && (win_nxt != WIN_EXP))
         err_win <= 1'b1;
   end
`else
   assign err_win = 1'b0;
`endif

   pix_gap_mon u_gap (
      .clk         (clk),
      .rstn        (rstn),
      .clr         (take_start),
      .en          (state == ST_CALC),
      .pix         (pix_valid_in),
      .err_overrun (err_overrun)
   );

endmodule

// File: tb/tb_layer_ctrl.sv
// Directed bench: stimulus pushes expected done events, a negedge monitor pops and compares.
module tb_layer_ctrl;

   localparam int NPIX  = 3136;
   localparam int NWIN  = 784;
   localparam int NPARM = 576;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic [7:0] frames_req = 8'd0;
   logic       param_valid = 1'b0;
   logic       vs_in = 1'b0;
   logic       pix_valid_in = 1'b0;
   logic       win_valid = 1'b0;
   logic       param_ready, param_we, mode_out, vs_out, pix_valid_out;
   logic       busy, frame_done, layer_done, err_overrun, err_win;
   logic [9:0] param_addr, win_count;

   layer_ctrl dut (
      .clk(clk), .rstn(rstn), .start(start), .frames_req(frames_req),
      .param_valid(param_valid), .param_ready(param_ready), .param_addr(param_addr),
      .param_we(param_we), .vs_in(vs_in), .pix_valid_in(pix_valid_in),
      .mode_out(mode_out), .vs_out(vs_out), .pix_valid_out(pix_valid_out),
      .win_valid(win_valid), .busy(busy), .frame_done(frame_done),
      .layer_done(layer_done), .err_overrun(err_overrun), .err_win(err_win),
      .win_count(win_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;   // 0 = frame_done, 1 = layer_done
      int at;
      int ovr;
      int werr;
      int wc;
   } exp_t;

   exp_t sbq[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int we_cnt = 0;
   int fwd_cnt = 0;
   int vs_cnt = 0;
   int layer_seen = 0;

`ifdef LAYER_CTRL_WINCHK_EN
   localparam int WINCHK = 1;
`else
   localparam int WINCHK = 0;
`endif

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin : monitor
      exp_t e;
      logic vs_d;
      vs_d = 1'b0;
      forever begin
         @(negedge clk);
         if (param_we) we_cnt++;
         if (pix_valid_out) fwd_cnt++;
         if (vs_out) vs_cnt++;
         if (vs_d) chk("win_count_clear_after_vs", win_count, 0);
         vs_d = vs_out;
         if (frame_done || layer_done) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done_pulse", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("done_kind", int'(layer_done), e.kind);
               chk("done_cycle", cyc, e.at);
               if (frame_done) begin
                  chk("err_overrun_at_frame_done", err_overrun, e.ovr);
                  chk("err_win_at_frame_done", err_win, e.werr);
                  chk("win_count_at_frame_done", win_count, e.wc);
               end else begin
                  chk("busy_at_layer_done", busy, 0);
                  chk("mode_at_layer_done", mode_out, 0);
                  layer_seen++;
               end
            end
         end
      end
   end

   task automatic send_vs();
      vs_in = 1'b1;
      tick();
      vs_in = 1'b0;
   endtask

   task automatic pixels(input int n, input int n_win, input int ovr_at, output int last_cyc);
      int w;
      w = 0;
      last_cyc = 0;
      for (int i = 0; i < n; i++) begin
         pix_valid_in = 1'b1;
         last_cyc = cyc;
         tick();
         pix_valid_in = 1'b0;
         if (i != ovr_at) begin
            win_valid = ((i % 4) == 3) && (w < n_win);
            if (win_valid) w++;
            tick();
            win_valid = 1'b0;
         end
      end
   endtask

   task automatic start_load(input int frames);
      int to;
      we_cnt = 0;
      frames_req = 8'(frames);
      start = 1'b1;
      tick();
      start = 1'b0;
      param_valid = 1'b1;
      to = 0;
      while (mode_out !== 1'b1 && to < 2000) begin
         tick();
         to++;
      end
      param_valid = 1'b0;
      chk("load_within_budget", int'(to < 2000), 1);
      chk("param_we_count", we_cnt, NPARM);
      chk("param_ready_after_load", param_ready, 0);
      chk("mode_after_load", mode_out, 1);
   endtask

   task automatic run_layer(input int frames, input int n_win, input int ovr_at,
                            input int abort_at, input int exp_ovr);
      int nf, last;
      exp_t e;
      nf = (frames == 0) ? 1 : frames;
      fwd_cnt = 0;
      vs_cnt = 0;
      layer_seen = 0;
      start_load(frames);
      for (int f = 0; f < nf; f++) begin
         // stray pixels while waiting for sync must be dropped
         pix_valid_in = 1'b1;
         tick();
         tick();
         pix_valid_in = 1'b0;
         tick();
         send_vs();
         if (f == 0 && abort_at > 0) begin
            pixels(abort_at, NWIN, -1, last);
            send_vs();
         end
         pixels(NPIX, n_win, ovr_at, last);
         e.kind = 0; e.at = last + 5; e.ovr = exp_ovr;
         e.werr = (WINCHK != 0 && n_win != NWIN) ? 1 : 0; e.wc = n_win;
         sbq.push_back(e);
         if (f == nf - 1) begin
            e.kind = 1; e.at = last + 6;
            sbq.push_back(e);
            while (cyc < last + 8) tick();
         end else begin
            while (cyc < last + 6) tick();
         end
      end
      chk("layer_done_seen", layer_seen, 1);
      chk("pixels_forwarded", fwd_cnt, nf * NPIX + abort_at);
      chk("vs_forwarded", vs_cnt, nf + ((abort_at > 0) ? 1 : 0));
      chk("busy_idle_after_layer", busy, 0);
   endtask

   initial begin : stim
      int to;
      // reset state
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_mode", mode_out, 0);
      chk("rst_param_ready", param_ready, 0);
      chk("rst_param_addr", param_addr, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_layer_done", layer_done, 0);
      chk("rst_err_overrun", err_overrun, 0);
      chk("rst_err_win", err_win, 0);
      chk("rst_win_count", win_count, 0);
      chk("rst_vs_out", vs_out, 0);
      rstn = 1'b1;
      tick();

      // reset in the middle of LOAD
      frames_req = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      param_valid = 1'b1;
      to = 0;
      while (param_addr != 10'd100 && to < 500) begin
         tick();
         to++;
      end
      chk("reached_addr_100", param_addr, 100);
      rstn = 1'b0;
      tick();
      param_valid = 1'b0;
      chk("midload_rst_busy", busy, 0);
      chk("midload_rst_param_ready", param_ready, 0);
      chk("midload_rst_param_addr", param_addr, 0);
      chk("midload_rst_mode", mode_out, 0);
      rstn = 1'b1;
      tick();
      tick();

      run_layer(1, NWIN, -1, 0, 0);        // single frame
      run_layer(3, NWIN, -1, 0, 0);        // multi-frame
      run_layer(1, NWIN, 500, 0, 1);       // overrun at pixel 500
      chk("err_overrun_sticky", err_overrun, 1);
      run_layer(1, NWIN, -1, 1000, 0);     // abort at pixel 1000
      run_layer(0, NWIN - 1, -1, 0, 0);    // short window count, frames_req 0 -> 1
      chk("err_win_after_short_frame", err_win, WINCHK);

      chk("scoreboard_drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
